exe_stage_unit: RTL

Execute stage of the five-stage pipeline, directly downstream of the decode-stage control unit. Consumes the 4-bit `EXE_CMD`, the memory/write-back/branch/S controls and the operand values latched at ID/EXE. Contains:
- the ALU;
- the second-operand (val2) generator;
- the NZCV status register;
- the branch-target adder;
- the registered EXE/MEM pipeline stage.

---
 rtl/arm_pkg.sv | 35 +++
 rtl/val2_generator.sv | 63 ++++++
 rtl/exe_stage_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// ---------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the execute stage of the five-stage pipeline:
//   - ALU command encodings produced by the decode-stage control unit
//   - barrel-shifter type codes taken from instruction bits [6:5]
//   - bit positions of the N, Z, C and V flags inside the 4-bit status word
// ---------------------------------------------------------------------------
package arm_pkg;

    // ALU commands as driven on exe_cmd
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;

    // Register-operand shift types
    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_type_e;

    // Flag bit positions inside the NZCV word
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/val2_generator.sv
// ---------------------------------------------------------------------------
// val2_generator
// Purely combinational second-operand generator for the ALU.
// Ports:
//   mem_en        in   1       load/store: val2 is the 12-bit offset, zero-extended
//   imm_in        in   1       val2 is the 8-bit immediate rotated right by 2*rot
//   val_rm        in   DATA_W  register operand for the shifted-register form
//   shift_operand in   12      instruction bits [11:0]
//   val2          out  DATA_W  generated second operand
// ---------------------------------------------------------------------------
module val2_generator
    import arm_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              mem_en,
    input  logic              imm_in,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [11:0]       shift_operand,
    output logic [DATA_W-1:0] val2
);

    logic [DATA_W-1:0] imm_ext;
    logic [4:0]        rot_amt;
    logic [DATA_W-1:0] imm_rot;
    logic [4:0]        shift_amt;
    shift_type_e       shift_type;
    logic [DATA_W-1:0] rm_shifted;

    // Rotations are built from two logical shifts; a rotate amount of zero
    // makes the left half shift by the full width, which yields zero and so
    // leaves the operand unchanged.
    assign imm_ext    = {{(DATA_W-8){1'b0}}, shift_operand[7:0]};
    assign rot_amt    = {shift_operand[11:8], 1'b0};
    assign imm_rot    = (imm_ext >> rot_amt) | (imm_ext << (DATA_W - int'(rot_amt)));
    assign shift_amt  = shift_operand[11:7];
    assign shift_type = shift_type_e'(shift_operand[6:5]);

    // Barrel shifter for the shifted-register operand form
    always_comb begin
        rm_shifted = val_rm;
        case (shift_type)
            SHIFT_LSL: rm_shifted = val_rm << shift_amt;
            SHIFT_LSR: rm_shifted = val_rm >> shift_amt;
            SHIFT_ASR: rm_shifted = $unsigned($signed(val_rm) >>> shift_amt);
            SHIFT_ROR: rm_shifted = (val_rm >> shift_amt) |
                                    (val_rm << (DATA_W - int'(shift_amt)));
            default:   rm_shifted = val_rm;
        endcase
    end

    // Operand select: memory offset beats immediate beats shifted register
    always_comb begin
        if (mem_en) begin
            val2 = {{(DATA_W-12){1'b0}}, shift_operand};
        end else if (imm_in) begin
            val2 = imm_rot;
        end else begin
            val2 = rm_shifted;
        end
    end

endmodule

// File: rtl/exe_stage_unit.sv
// ---------------------------------------------------------------------------
// exe_stage_unit
// Execute stage: val2 generation, ALU, NZCV status register, branch-target
// adder and the EXE/MEM pipeline register.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   freeze                    hold EXE/MEM register and status register
//   flush                     load a bubble into EXE/MEM register
//   exe_cmd                   ALU command from decode
//   wb_en_in, mem_r_in,
//   mem_w_in, b_in, s_in      decode controls
//   imm_in                    operand 2 is a rotated immediate
//   pc_in                     PC+4 of this instruction
//   val_rn, val_rm            register operands
//   shift_operand             instruction bits [11:0]
//   signed_imm_24             branch offset in words
//   dest_in                   destination register
//   status_out                current NZCV for decode condition checks
//   branch_taken, branch_addr combinational branch redirect
//   alu_res_out, val_rm_out,
//   wb_en_out, mem_r_out,
//   mem_w_out, dest_out       registered EXE/MEM outputs
// ---------------------------------------------------------------------------
module exe_stage_unit
    import arm_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic [3:0]            exe_cmd,
    input  logic                  wb_en_in,
    input  logic                  mem_r_in,
    input  logic                  mem_w_in,
    input  logic                  b_in,
    input  logic                  s_in,
    input  logic                  imm_in,
    input  logic [DATA_W-1:0]     pc_in,
    input  logic [DATA_W-1:0]     val_rn,
    input  logic [DATA_W-1:0]     val_rm,
    input  logic [11:0]           shift_operand,
    input  logic [23:0]           signed_imm_24,
    input  logic [REG_ADDR_W-1:0] dest_in,
    output logic [3:0]            status_out,
    output logic                  branch_taken,
    output logic [DATA_W-1:0]     branch_addr,
    output logic [DATA_W-1:0]     alu_res_out,
    output logic [DATA_W-1:0]     val_rm_out,
    output logic                  wb_en_out,
    output logic                  mem_r_out,
    output logic                  mem_w_out,
    output logic [REG_ADDR_W-1:0] dest_out
);

    logic                  mem_en;
    logic [DATA_W-1:0]     val2;
    logic [3:0]            alu_cmd;
    logic [DATA_W:0]       sum_ext;
    logic [DATA_W-1:0]     alu_res;
    logic                  carry;
    logic                  overflow;
    logic                  cmd_valid;
    logic [3:0]            next_status;
    logic [3:0]            status;
    logic [DATA_W:0]       op_a;
    logic [DATA_W:0]       op_b;
    logic [DATA_W:0]       op_b_n;
    logic [DATA_W:0]       c_in_ext;
    logic [DATA_W-1:0]     offset_ext;

    assign mem_en = mem_r_in | mem_w_in;

    val2_generator #(
        .DATA_W(DATA_W)
    ) u_val2 (
        .mem_en       (mem_en),
        .imm_in       (imm_in),
        .val_rm       (val_rm),
        .shift_operand(shift_operand),
        .val2         (val2)
    );

    // Loads and stores compute their address as base plus offset, so the
    // command from decode is overridden for them.
    assign alu_cmd  = mem_en ? EXE_ADD : exe_cmd;

    // Operands widened by one bit so the top bit of the sum is the carry.
    // Subtraction is A + ~B + 1, which makes the carry an active no-borrow.
    assign op_a     = {1'b0, val_rn};
    assign op_b     = {1'b0, val2};
    assign op_b_n   = {1'b0, ~val2};
    assign c_in_ext = {{DATA_W{1'b0}}, status[FLAG_C]};

    // ALU: result plus carry/overflow; logical ops keep the held C and V,
    // undefined commands give zero and leave every flag alone
    always_comb begin
        sum_ext   = '0;
        alu_res   = '0;
        carry     = status[FLAG_C];
        overflow  = status[FLAG_V];
        cmd_valid = 1'b1;
        case (alu_cmd)
            EXE_MOV: alu_res = val2;
            EXE_MVN: alu_res = ~val2;
            EXE_ADD, EXE_ADC: begin
                sum_ext  = op_a + op_b + ((alu_cmd == EXE_ADC) ? c_in_ext : '0);
                alu_res  = sum_ext[DATA_W-1:0];
                carry    = sum_ext[DATA_W];
                overflow = (val_rn[DATA_W-1] == val2[DATA_W-1]) &&
                           (alu_res[DATA_W-1] != val_rn[DATA_W-1]);
            end
            EXE_SUB, EXE_SBC: begin
                sum_ext  = op_a + op_b_n +
                           ((alu_cmd == EXE_SBC) ? c_in_ext : (DATA_W+1)'(1));
                alu_res  = sum_ext[DATA_W-1:0];
                carry    = sum_ext[DATA_W];
                overflow = (val_rn[DATA_W-1] != val2[DATA_W-1]) &&
                           (alu_res[DATA_W-1] != val_rn[DATA_W-1]);
            end
            EXE_AND: alu_res = val_rn & val2;
            EXE_ORR: alu_res = val_rn | val2;
            EXE_EOR: alu_res = val_rn ^ val2;
            default: cmd_valid = 1'b0;
        endcase
    end

    // Assemble the candidate NZCV word for the status register
    always_comb begin
        next_status = status;
        if (cmd_valid) begin
            next_status[FLAG_N] = alu_res[DATA_W-1];
            next_status[FLAG_Z] = (alu_res == '0);
            next_status[FLAG_C] = carry;
            next_status[FLAG_V] = overflow;
        end
    end

    // Status register: branches never set flags, and a stalled pipeline
    // must not commit flags from an instruction that will be replayed
    always_ff @(posedge clk) begin
        if (rst) begin
            status <= 4'b0000;
        end else if (s_in && !freeze && !b_in) begin
            status <= next_status;
        end
    end

    assign status_out = status;

    // Branch target: word offset sign-extended and scaled to bytes
    assign offset_ext   = {{(DATA_W-24){signed_imm_24[23]}}, signed_imm_24};
    assign branch_addr  = pc_in + (offset_ext << 2);
    assign branch_taken = b_in;

    // EXE/MEM register: flush wins over freeze so a bubble can be inserted
    // even while the rest of the pipe is stalled
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            alu_res_out <= '0;
            val_rm_out  <= '0;
            wb_en_out   <= 1'b0;
            mem_r_out   <= 1'b0;
            mem_w_out   <= 1'b0;
            dest_out    <= '0;
        end else if (!freeze) begin
            alu_res_out <= alu_res;
            val_rm_out  <= val_rm;
            wb_en_out   <= wb_en_in;
            mem_r_out   <= mem_r_in;
            mem_w_out   <= mem_w_in;
            dest_out    <= dest_in;
        end
    end

endmodule
